// File: rtl/sumador_sat_acc.sv
// sumador_sat_acc: two-stage saturating adder/accumulator.
// Stage 1 reduces N signed operands to one full-precision sum.
// Stage 2 optionally adds the running accumulator, clamps the result to
// the signed W-bit range, and maintains a sticky overflow flag.
module sumador_sat_acc #(
  parameter int unsigned W = 19,
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           Reset,
  input  logic           valid_in,
  input  logic [N*W-1:0] data_in,
  input  logic           Mode,
  input  logic           Clear,
  output logic [W-1:0]   Sout,
  output logic           valid_out,
  output logic           Ovf
);

  // The sum of N operands grows by at most clog2(N) bits.
  localparam int unsigned S = W + $clog2(N);

  // Clamp limits, expressed in the S+1 bit width of the stage-2 sum.
  localparam logic signed [S:0] MAX_T = {{(S + 2 - W){1'b0}}, {(W - 1){1'b1}}};
  localparam logic signed [S:0] MIN_T = {{(S + 2 - W){1'b1}}, {(W - 1){1'b0}}};

  // Stage 1 state.
  logic signed [S-1:0] sum1_d, sum1_q;
  logic                v1_q;
  logic                m1_q;

  // Stage 2 state.
  logic [W-1:0]        sout_d, sout_q;
  logic                ovf_d, ovf_q;
  logic                vout_q;

  // Stage 2 intermediates.
  logic signed [S:0]   base;
  logic signed [S:0]   t;
  logic                sat_hi;
  logic                sat_lo;

  // Full-precision reduction of all operands; no intermediate clamping.
  always_comb begin
    sum1_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum1_d = sum1_d + $signed({{(S - W){data_in[k*W + W - 1]}}, data_in[k*W +: W]});
    end
  end

  // Stage 1 pipeline register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sum1_q <= '0;
      v1_q   <= 1'b0;
      m1_q   <= 1'b0;
    end else begin
      sum1_q <= sum1_d;
      v1_q   <= valid_in;
      m1_q   <= Mode;
    end
  end

  // Accumulate-and-clamp: the clamped output is the accumulator, so a
  // saturated value is what feeds back and wrap-around cannot occur.
  always_comb begin
    base   = '0;
    if (!Clear && m1_q) begin
      base = $signed({{(S + 1 - W){sout_q[W-1]}}, sout_q});
    end
    t      = base + $signed({sum1_q[S-1], sum1_q});
    sat_hi = (t > MAX_T);
    sat_lo = (t < MIN_T);

    sout_d = sout_q;
    ovf_d  = ovf_q;
    if (v1_q) begin
      if (sat_hi) begin
        sout_d = {1'b0, {(W - 1){1'b1}}};
      end else if (sat_lo) begin
        sout_d = {1'b1, {(W - 1){1'b0}}};
      end else begin
        sout_d = t[W-1:0];
      end
      // Clear restarts the sticky history from this update alone.
      ovf_d = (sat_hi || sat_lo) || (ovf_q && !Clear);
    end else if (Clear) begin
      sout_d = '0;
      ovf_d  = 1'b0;
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sout_q <= '0;
      ovf_q  <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      sout_q <= sout_d;
      ovf_q  <= ovf_d;
      vout_q <= v1_q;
    end
  end

  assign Sout      = sout_q;
  assign Ovf       = ovf_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_sumador_sat_acc.sv
// Directed bench for sumador_sat_acc with W=19, N=4.
module tb_sumador_sat_acc;

  localparam int unsigned W = 19;
  localparam int unsigned N = 4;

  logic           clk;
  logic           Reset;
  logic           valid_in;
  logic [N*W-1:0] data_in;
  logic           Mode;
  logic           Clear;
  logic [W-1:0]   Sout;
  logic           valid_out;
  logic           Ovf;

  int tests_run = 0;
  int tests_failed = 0;

  sumador_sat_acc #(.W(W), .N(N)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .Mode      (Mode),
    .Clear     (Clear),
    .Sout      (Sout),
    .valid_out (valid_out),
    .Ovf       (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one beat (or idle/clear) to be sampled at the next rising edge.
  task automatic drive(input logic v, input int a0, input int a1, input int a2,
                       input int a3, input logic m, input logic c);
    logic [W-1:0] o0, o1, o2, o3;
    o0 = W'(a0);
    o1 = W'(a1);
    o2 = W'(a2);
    o3 = W'(a3);
    valid_in = v;
    data_in  = {o3, o2, o1, o0};
    Mode     = m;
    Clear    = c;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b0;
    idle();
    #2;
    chk("rst_sout", 32'(Sout), 32'd0);
    chk("rst_vout", 32'(valid_out), 32'd0);
    chk("rst_ovf", 32'(Ovf), 32'd0);
    step();
    step();
    Reset = 1'b1;

    // Basic sum, two-edge latency, single-cycle valid pulse, hold.
    drive(1'b1, 1, 2, 3, 4, 1'b0, 1'b0);
    step();
    idle();
    chk("lat1_vout", 32'(valid_out), 32'd0);
    step();
    chk("sum10", 32'(Sout), 32'd10);
    chk("sum10_vout", 32'(valid_out), 32'd1);
    chk("sum10_ovf", 32'(Ovf), 32'd0);
    step();
    chk("pulse_end", 32'(valid_out), 32'd0);
    step();
    chk("hold10", 32'(Sout), 32'd10);

    // Full-precision intermediate: no false saturation.
    drive(1'b1, 262143, 1, -1, 0, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("fullprec", 32'(Sout), 32'h3FFFF);
    chk("fullprec_ovf", 32'(Ovf), 32'd0);

    // Positive saturation.
    drive(1'b1, 262143, 262143, 262143, 262143, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("sat_pos", 32'(Sout), 32'h3FFFF);
    chk("sat_pos_ovf", 32'(Ovf), 32'd1);

    // Clear with no beat, then negative saturation.
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    step();
    idle();
    chk("clr_sout", 32'(Sout), 32'd0);
    chk("clr_ovf", 32'(Ovf), 32'd0);
    drive(1'b1, -262144, -262144, -262144, -262144, 1'b0, 1'b0);
    step();
    idle();
    step();
    chk("sat_neg", 32'(Sout), 32'h40000);
    chk("sat_neg_ovf", 32'(Ovf), 32'd1);

    // Accumulate: Clear aligned with the first beat's stage-2 update.
    drive(1'b1, 100000, 0, 0, 0, 1'b1, 1'b0);
    step();
    drive(1'b1, 100000, 0, 0, 0, 1'b1, 1'b1);
    step();
    chk("acc1", 32'(Sout), 32'd100000);
    chk("acc1_ovf", 32'(Ovf), 32'd0);
    drive(1'b1, 100000, 0, 0, 0, 1'b1, 1'b0);
    step();
    chk("acc2", 32'(Sout), 32'd200000);
    chk("acc2_vout", 32'(valid_out), 32'd1);
    drive(1'b1, -62143, 0, 0, 0, 1'b1, 1'b0);
    step();
    chk("acc3_sat", 32'(Sout), 32'h3FFFF);
    chk("acc3_ovf", 32'(Ovf), 32'd1);
    idle();
    step();
    chk("acc4", 32'(Sout), 32'd200000);
    chk("acc4_ovf", 32'(Ovf), 32'd1);
    drive(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
    step();
    idle();
    chk("clr2_sout", 32'(Sout), 32'd0);
    chk("clr2_ovf", 32'(Ovf), 32'd0);
    chk("clr2_vout", 32'(valid_out), 32'd0);

    // Asynchronous reset mid-stream.
    drive(1'b1, 5, 5, 5, 5, 1'b1, 1'b0);
    step();
    drive(1'b1, 5, 5, 5, 5, 1'b1, 1'b0);
    step();
    idle();
    chk("pre_rst_sout", 32'(Sout), 32'd20);
    Reset = 1'b0;
    #1;
    chk("arst_sout", 32'(Sout), 32'd0);
    chk("arst_vout", 32'(valid_out), 32'd0);
    chk("arst_ovf", 32'(Ovf), 32'd0);
    step();
    chk("rst_hold_vout", 32'(valid_out), 32'd0);
    Reset = 1'b1;
    step();
    chk("post_rst_vout1", 32'(valid_out), 32'd0);
    step();
    chk("post_rst_vout2", 32'(valid_out), 32'd0);
    drive(1'b1, 1, 0, 0, 0, 1'b1, 1'b0);
    step();
    idle();
    step();
    chk("post_rst_sum", 32'(Sout), 32'd1);
    chk("post_rst_v", 32'(valid_out), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sumador_sat_acc.md
# sumador_sat_acc

Pipelined, parametrised saturating adder/accumulator for the fixed-point datapath. Each valid beat sums N signed W-bit operands at full precision, optionally adds the running accumulator, and clamps the result to the signed W-bit range. A sticky overflow flag records saturation. The block succeeds the two-operand combinational saturating adder and sits between the multiplier outputs and the filter output register.

## Interface

Parameters:
- W, 19: operand, accumulator-output and result width, signed two's complement.
- N, 4: operands per beat, 2..16. Define S = W + clog2(N).

Ports:
- clk  in  1  sole clock; rising edge.
- Reset  in  1  asynchronous, active-low reset.
- valid_in  in  1  beat qualifier; no backpressure, accepted every cycle.
- data_in  in  N*W  operand k occupies bits [k*W+W-1 : k*W], signed.
- Mode  in  1  0 = sum only, 1 = accumulate; sampled with valid_in.
- Clear  in  1  synchronous accumulator clear, acts on stage 2.
- Sout  out  W  saturated result, signed, registered.
- valid_out  out  1  Sout updated this cycle.
- Ovf  out  1  sticky: saturation occurred since the last Clear or reset.

## Operation

- Stage 1, registered:
  - sum1 = sign-extended sum of all N operands in S bits. This never overflows.
  - v1 <= valid_in, m1 <= Mode.
- Stage 2, registered, updates only when v1 = 1:
  - base = 0 if Clear = 1 or m1 = 0; otherwise base = acc, the last Sout sign-extended.
  - t = base + sum1, computed in S+1 bits.
  - If t > 2^(W-1)-1, Sout <= 2^(W-1)-1 (W=19: 0x3FFFF = 262143) and Ovf <= 1.
  - If t < -2^(W-1), Sout <= -2^(W-1) (W=19: 0x40000 = -262144) and Ovf <= 1.
  - Otherwise Sout <= t[W-1:0].
  - acc equals Sout after every update. Saturation feeds back, so no wrap-around ever occurs.
- Clear:
  - Clear = 1 with v1 = 0: Sout <= 0, Ovf <= 0, valid_out <= 0.
  - Clear = 1 with v1 = 1: base is 0 and Ovf <= (this update saturates).
- Mode applies per beat, so mode changes mid-stream are legal. A Mode 0 beat restarts the accumulation from its own sum.
- Intermediate sums are full precision. Saturation is applied only to the final t, never to partial sums.
- When v1 = 0 and Clear = 0, Sout and Ovf hold their values.

## Timing

- Reset low, asynchronous: Sout = 0, valid_out = 0, Ovf = 0, v1 = 0, sum1 = 0, m1 = 0.
- Deassertion of Reset is synchronised externally. The first beat is accepted on the first rising edge with Reset high.
- Latency: a beat presented at edge k produces Sout and valid_out = 1 after edge k+2.
- Throughput: 1 beat per cycle. Back-to-back Mode 1 beats accumulate every cycle with no bubbles.
- valid_out <= v1 each cycle. It is a one-cycle pulse per beat.
- Clear is sampled at the edge where stage 2 updates, i.e. it aligns with the beat presented one cycle earlier.
- Reset asserted mid-stream: in-flight beats are discarded and no valid_out is produced for them.

## Test plan

- Mode 0, operands {1, 2, 3, 4}, valid_in for one cycle:
  - 2 edges later, Sout = 10, valid_out pulses for one cycle, Ovf = 0.
  - Sout still equals 10 after further idle cycles.
- Mode 0, operands {262143, 1, -1, 0}:
  - Sout = 262143, Ovf = 0 (full-precision intermediate, no false saturation).
- Mode 0, operands 4 × 262143:
  - Sout = 262143, Ovf = 1.
- Mode 0, operands 4 × -262144:
  - Sout = -262144 (0x40000), Ovf = 1.
- Mode 1, operands {100000, 0, 0, 0} on 3 consecutive beats, Clear on the first beat:
  - Sout = 100000, 200000, 262143 on 3 consecutive cycles; Ovf = 1 after the third.
  - Next beat with operands {-62143, 0, 0, 0}: Sout = 200000 and Ovf stays 1.
  - Then Clear with no beat: Sout = 0, Ovf = 0.
- Reset:
  - Send two Mode 1 beats of {5, 5, 5, 5}, then pull Reset low one cycle after the second beat.
  - Sout = 0, valid_out = 0 and Ovf = 0 immediately, without waiting for a clock edge.
  - No further valid_out occurs.
  - After release, one Mode 1 beat of {1, 0, 0, 0} gives Sout = 1.
